// File: rtl/tick_timer_pkg.sv
// Shared types and defaults for the tick_timer countdown block.
// Optional auto-reload is enabled with TICK_TIMER_AUTO_RELOAD_EN.
package tick_timer_pkg;

  localparam int TT_CNT_W       = 8;
  localparam int TT_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } tt_state_e;

endpackage

// File: rtl/tick_timer_edge_det.sv
// Synchroniser plus registered rising-edge detector for the divided clock.
// The divided clock is treated purely as data in the clk domain.
module edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic tick
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   tick_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
      hist_q <= sync_q[SYNC_STAGES-1];
      tick_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/tick_timer.sv
// Programmable countdown timer advanced by ticks from the divided clock.
// Define TICK_TIMER_AUTO_RELOAD_EN for periodic reload instead of one-shot.
module tick_timer
  import tick_timer_pkg::*;
#(
  parameter int CNT_W       = TT_CNT_W,
  parameter int SYNC_STAGES = TT_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk2_in,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt_out,
  output logic             busy,
  output logic             done
);

  tt_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             tick;

  edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .d_in (clk2_in),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          if (load_val != '0) begin
            cnt_d   = load_val;
            state_d = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        // stop wins over a coincident tick
        if (stop) begin
          state_d = S_PAUSE;
        end else if (tick && cnt_q != '0) begin
          if (cnt_q != CNT_W'(1)) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
`ifdef TICK_TIMER_AUTO_RELOAD_EN
            if (load_val != '0) begin
              cnt_d  = load_val;
              done_d = 1'b1;
            end else begin
              cnt_d   = '0;
              state_d = S_DONE;
            end
`else
            cnt_d   = '0;
            state_d = S_DONE;
`endif
          end
        end
      end
      S_PAUSE: begin
        if (stop) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (start) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (state_d == S_DONE) begin
      done_d = 1'b1;
    end
    busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign cnt_out = cnt_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_tick_timer.sv
// Directed bench for tick_timer with a done-event scoreboard.
// Auto-reload scenarios run when TICK_TIMER_AUTO_RELOAD_EN is defined.
module tb_tick_timer;

  localparam int CW = 8;
  localparam int SS = 2;

  typedef struct {
    logic [CW-1:0] cnt;
    logic          busy;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk2_in;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [CW-1:0] load_val = '0;
  logic [CW-1:0] cnt_out;
  logic          busy;
  logic          done;
  logic [1:0]    div_q;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  tick_timer #(
    .CNT_W      (CW),
    .SYNC_STAGES(SS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk2_in (clk2_in),
    .start   (start),
    .stop    (stop),
    .load_val(load_val),
    .cnt_out (cnt_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // upstream clk/4 divider
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= 2'd0;
    else        div_q <= div_q + 2'd1;
  end
  assign clk2_in = div_q[1];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: every done pulse must match a queued expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done=1 expected none (cnt=%0d)",
                 cnt_out);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (cnt_out !== e.cnt || busy !== e.busy) begin
          errors++;
          $display("FAIL done_state: got cnt=%0d busy=%0b expected cnt=%0d busy=%0b",
                   cnt_out, busy, e.cnt, e.busy);
        end
      end
    end
  end

  task automatic wait_tick();
    int n = 0;
    while (!dut.u_edge.tick && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!dut.u_edge.tick) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: got no tick expected tick within 20 cycles");
    end
  endtask

  task automatic pulse_start(input logic [CW-1:0] v);
    load_val = v;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic test_edges();
    int n = 0;
    int last = -1;
    logic prev = 1'b0;
    while (!clk2_in && n < 10) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!dut.u_edge.tick && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("tick_latency", n, SS + 1);
    for (int c = 0; c < 40; c++) begin
      if (dut.u_edge.tick) begin
        chk("tick_width", {31'd0, prev}, 0);
        if (last >= 0) chk("tick_gap", c - last, 4);
        last = c;
      end
      prev = dut.u_edge.tick;
      @(negedge clk);
    end
    chk("idle_cnt", cnt_out, 0);
    chk("idle_busy", busy, 0);
  endtask

  task automatic test_oneshot();
    sb_q.push_back('{cnt: 8'd0, busy: 1'b0});
    pulse_start(8'd3);
    chk("os_busy", busy, 1);
    chk("os_load", cnt_out, 3);
    wait_tick();
    @(negedge clk);
    chk("os_cnt2", cnt_out, 2);
    wait_tick();
    @(negedge clk);
    chk("os_cnt1", cnt_out, 1);
    wait_tick();
    @(negedge clk);
    chk("os_done", done, 1);
    @(negedge clk);
    chk("os_done_width", done, 0);
    chk("os_busy_end", busy, 0);
  endtask

  task automatic test_pause();
    pulse_start(8'd5);
    wait_tick();
    @(negedge clk);
    wait_tick();
    @(negedge clk);
    chk("pr_cnt3", cnt_out, 3);
    wait_tick();
    pulse_stop();
    chk("pr_stop_tick", cnt_out, 3);
    repeat (20) @(negedge clk);
    chk("pr_hold_cnt", cnt_out, 3);
    chk("pr_hold_busy", busy, 1);
    sb_q.push_back('{cnt: 8'd0, busy: 1'b0});
    pulse_start(8'd9);
    wait_tick();
    @(negedge clk);
    chk("pr_cnt2", cnt_out, 2);
    wait_tick();
    @(negedge clk);
    chk("pr_cnt1", cnt_out, 1);
    wait_tick();
    @(negedge clk);
    chk("pr_done", done, 1);
    @(negedge clk);
  endtask

  task automatic test_abort();
    pulse_start(8'd4);
    wait_tick();
    @(negedge clk);
    pulse_stop();
    chk("ab_paused", busy, 1);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    chk("ab_cnt", cnt_out, 0);
    chk("ab_busy", busy, 0);
    repeat (12) @(negedge clk);
    chk("ab_stay_idle", busy, 0);
  endtask

  task automatic test_zero_and_idle();
    sb_q.push_back('{cnt: 8'd0, busy: 1'b0});
    pulse_start(8'd0);
    chk("z_done", done, 1);
    chk("z_busy", busy, 0);
    @(negedge clk);
    chk("z_after", done, 0);
    load_val = 8'd5;
    start    = 1'b1;
    stop     = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    stop     = 1'b0;
    chk("ss_idle_busy", busy, 0);
    chk("ss_idle_cnt", cnt_out, 0);
  endtask

  task automatic test_reset();
    pulse_start(8'd6);
    wait_tick();
    @(negedge clk);
    wait_tick();
    @(negedge clk);
    chk("rs_cnt4", cnt_out, 4);
    rst_n = 1'b0;
    #1;
    chk("rs_cnt", cnt_out, 0);
    chk("rs_busy", busy, 0);
    chk("rs_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (16) @(negedge clk);
    chk("rs_idle", busy, 0);
  endtask

`ifdef TICK_TIMER_AUTO_RELOAD_EN
  task automatic test_reload();
    pulse_start(8'd2);
    chk("ar_load", cnt_out, 2);
    for (int p = 0; p < 3; p++) begin
      sb_q.push_back('{cnt: 8'd2, busy: 1'b1});
      wait_tick();
      @(negedge clk);
      chk("ar_cnt1", cnt_out, 1);
      wait_tick();
      @(negedge clk);
      chk("ar_done", done, 1);
      chk("ar_reload", cnt_out, 2);
      chk("ar_busy", busy, 1);
    end
    pulse_stop();
    chk("ar_pause", busy, 1);
    pulse_stop();
    chk("ar_idle", busy, 0);
  endtask
`endif

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cnt", cnt_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    test_edges();
`ifdef TICK_TIMER_AUTO_RELOAD_EN
    test_reload();
`else
    test_oneshot();
    test_pause();
`endif
    test_abort();
    test_zero_and_idle();
    test_reset();
    repeat (4) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_timer.md
Name: tick_timer

Overview:
- Programmable countdown timer; directly downstream of the clock-divider counter.
- Consumes the divided clock (clk/4 square wave) as a data signal in the clk domain. It does not clock any flops from it.
- Synchronises that signal and converts each rising edge into a one-cycle tick. Counts ticks down from a loaded value and flags completion.

Parameters:
- CNT_W, 8, width of load value and countdown register.
- SYNC_STAGES, 2, synchroniser depth on clk2_in (legal: 2..4).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset.
- clk2_in  input  1  divided clock from upstream counter, sampled as data.
- start  input  1  level-sampled each cycle; begins or resumes countdown.
- stop  input  1  level-sampled each cycle; pauses, or aborts when paused.
- load_val  input  CNT_W  initial count, captured on start from IDLE.
- cnt_out  output  CNT_W  current remaining count.
- busy  output  1  high in RUN or PAUSE.
- done  output  1  one-cycle pulse on countdown completion.

Interface: reset rst_n, asynchronous, active-low; clock clk.

Behaviour:
- Reset: all flops clear to 0 (synchroniser, edge flop, state=IDLE, cnt_out=0, busy=0, done=0). Reset mid-count aborts silently; no done pulse.
- Tick generation:
  - clk2_in passes through SYNC_STAGES flops, then one history flop.
  - tick = sync_last & ~hist, registered. It is high exactly 1 cycle per clk2_in rising edge.
  - Latency from clk2_in rise to tick high = SYNC_STAGES+1 clk edges.
  - With clk2 = clk/4, one tick every 4 clk cycles.
- States: IDLE, RUN, PAUSE, DONE. All transitions are registered.
- IDLE:
  - start=1, stop=0, load_val!=0: cnt<=load_val, go to RUN.
  - start=1, stop=0, load_val==0: go to DONE (cnt stays 0).
  - All other inputs: stay in IDLE.
- RUN:
  - stop=1: go to PAUSE, cnt held. Stop has priority over tick in the same cycle; no decrement.
  - tick=1 and cnt>1: cnt<=cnt-1.
  - tick=1 and cnt==1: cnt<=0, go to DONE.
  - start is ignored in RUN.
- PAUSE:
  - stop=1: go to IDLE, cnt<=0, no done. Stop has priority when start and stop are both high.
  - start=1 (stop=0): go back to RUN with cnt unchanged.
  - Ticks are ignored while in PAUSE.
- DONE:
  - done=1 for exactly this one cycle; the next state is IDLE unconditionally.
  - start and stop are ignored in DONE.
- Outputs are all registered:
  - busy=1 iff state is RUN or PAUSE.
  - cnt_out is the count register.
  - done=1 iff state is DONE.
- Simultaneous start and stop in IDLE: no action.
- Counter never wraps: decrement only when cnt>=1.

Optional Feature:
- Macro: TICK_TIMER_AUTO_RELOAD_EN.
- Defined: on RUN with tick and cnt==1:
  - cnt<=load_val (current value) and state stays RUN.
  - done pulses 1 cycle (separately registered); busy stays 1.
  - If the current load_val==0, take the normal DONE then IDLE path.
  - Only stop leaves RUN.
- Undefined: one-shot behaviour exactly as described above; the reload logic is absent.

Decomposition:
- Package tick_timer_pkg holds:
  - state enum typedef (IDLE, RUN, PAUSE, DONE);
  - default CNT_W and SYNC_STAGES localparams.
- Sub-module edge_det holds the synchroniser chain, history flop and registered rising-edge tick. Parameter SYNC_STAGES; ports clk, rst_n, d_in, tick.
- Top-level tick_timer holds the FSM and counter.

Test Plan:
- Edge detection: drive clk2_in from the upstream clk/4 divider, idle for 40 cycles. Expect tick pulses 1 cycle wide, 4 cycles apart, first at SYNC_STAGES+1 edges after the first rise; cnt_out=0, busy=0.
- One-shot: load_val=3, pulse start. Expect busy=1 next cycle, cnt_out 3→2→1→0 on successive ticks, done high 1 cycle on the 3rd tick, then busy=0, state IDLE.
- Pause/resume: load_val=5, start; assert stop with cnt_out=3, hold 20 cycles. Expect cnt_out stays 3, busy=1. Then start: countdown resumes and done fires after 3 more ticks.
- Abort and priority:
  - In PAUSE, assert start+stop together: expect IDLE, cnt_out=0, busy=0, no done.
  - In RUN, stop coincident with tick: no decrement.
- Zero load and reset: start with load_val=0 → done 1 cycle later, busy never 1. Separately, assert rst_n=0 mid-count at cnt_out=4 → outputs 0 immediately, no done.
- TICK_TIMER_AUTO_RELOAD_EN build: load_val=2, start. Expect done every 2 ticks (8 clk), cnt_out 2→1→2→1…, busy stays 1 until stop.
